arb2t1_8b: RTL and testbench

Round-robin arbiter and output stage that shares one 8-bit 2:1 mux datapath (`mux2t1_8b`) between two requesters, A and B. It accepts a word from one requester per cycle, drives the mux `Sel`, and registers the selected word into a one-entry output buffer with a valid/ready handshake toward the consumer. It sits between two 8-bit producers and a single downstream 8-bit sink.

---
 rtl/arb2t1_8b.sv | 128 ++++++++++++
 tb/tb_arb2t1_8b.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/arb2t1_8b.sv
// arb2t1_8b: round-robin arbiter for two 8-bit requesters sharing one
// 2:1 mux, followed by a one-entry valid/ready output buffer.

// Plain 8-bit 2:1 multiplexer (0 = A, 1 = B), built bit by bit.
module mux2t1_8b (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Sel,
    output logic [7:0] F
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_bit
            assign F[gi] = Sel ? B[gi] : A[gi];
        end
    endgenerate

endmodule

module arb2t1_8b #(
    parameter logic FIRST_PRI = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ReqA,
    input  logic [7:0] A,
    input  logic       ReqB,
    input  logic [7:0] B,
    output logic       GntA,
    output logic       GntB,
    output logic       Sel,
    output logic [7:0] F,
    output logic       FValid,
    input  logic       FReady
);

    // Output buffer occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t state_reg;
    buf_state_t state_next;
    logic       last_reg;
    logic       last_next;
    logic [7:0] f_reg;
    logic [7:0] f_next;

    logic [7:0] mux_f;
    logic       load;
    logic       sel_c;
    logic       grant;

    // Shared datapath: the only source of words for the F register.
    mux2t1_8b u_mux (
        .A   (A),
        .B   (B),
        .Sel (sel_c),
        .F   (mux_f)
    );

    // The buffer accepts a word when empty or when it drains on this edge.
    assign load = (state_reg == EMPTY) | FReady;

    // Requester choice: a lone requester wins; on a tie or when idle the
    // requester other than the last winner is selected.
    always_comb begin
        sel_c = ~last_reg;
        if (ReqA && !ReqB) begin
            sel_c = 1'b0;
        end else if (ReqB && !ReqA) begin
            sel_c = 1'b1;
        end
    end

    // Grants are void while reset is asserted, since the edge will discard them.
    assign GntA  = ~rst & load & ReqA & ~sel_c;
    assign GntB  = ~rst & load & ReqB &  sel_c;
    assign grant = GntA | GntB;

    // Next-state, data and priority update for the output buffer.
    always_comb begin
        state_next = state_reg;
        f_next     = f_reg;
        last_next  = last_reg;
        if (grant) begin
            f_next    = mux_f;
            last_next = sel_c;
        end
        case (state_reg)
            EMPTY: begin
                if (grant) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                // Drain plus grant keeps the buffer full with no bubble.
                if (!grant && FReady) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // State registers; reset discards any buffered word and arms FIRST_PRI
    // to win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            f_reg     <= 8'h00;
            last_reg  <= ~FIRST_PRI;
        end else begin
            state_reg <= state_next;
            f_reg     <= f_next;
            last_reg  <= last_next;
        end
    end

    assign Sel    = sel_c;
    assign F      = f_reg;
    assign FValid = (state_reg == FULL);

endmodule

// File: tb/tb_arb2t1_8b.sv
// Directed bench for arb2t1_8b: one instance with FIRST_PRI=0 (main) and one
// with FIRST_PRI=1 sharing the same inputs, used only for first-tie checks.
module tb_arb2t1_8b;

    logic       clk = 1'b0;
    logic       rst;
    logic       ReqA;
    logic [7:0] A;
    logic       ReqB;
    logic [7:0] B;
    logic       FReady;

    logic       GntA0, GntB0, Sel0, FValid0;
    logic [7:0] F0;
    logic       GntA1, GntB1, Sel1, FValid1;
    logic [7:0] F1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb2t1_8b #(.FIRST_PRI(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .ReqA(ReqA), .A(A), .ReqB(ReqB), .B(B),
        .GntA(GntA0), .GntB(GntB0), .Sel(Sel0),
        .F(F0), .FValid(FValid0), .FReady(FReady)
    );

    arb2t1_8b #(.FIRST_PRI(1'b1)) dut1 (
        .clk(clk), .rst(rst),
        .ReqA(ReqA), .A(A), .ReqB(ReqB), .B(B),
        .GntA(GntA1), .GntB(GntB1), .Sel(Sel1),
        .F(F1), .FValid(FValid1), .FReady(FReady)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; one line per transaction.
    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b ReqA=%b ReqB=%b FReady=%b | F=%h FValid=%b",
                 $time, rst, ReqA, ReqB, FReady, F0, FValid0);
    endtask

    initial begin
        rst = 1'b1; ReqA = 1'b0; ReqB = 1'b0; A = 8'h3C; B = 8'hC3; FReady = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_F", F0, 8'h00);
        chk("reset_FValid", {7'd0, FValid0}, 8'h00);
        chk("reset_F_pri1", F1, 8'h00);

        // First tie after reset
        ReqA = 1'b1; ReqB = 1'b1;
        #1;
        chk("tie0_GntA", {7'd0, GntA0}, 8'h01);
        chk("tie0_GntB", {7'd0, GntB0}, 8'h00);
        chk("tie0_Sel", {7'd0, Sel0}, 8'h00);
        chk("tie1_GntB", {7'd0, GntB1}, 8'h01);
        chk("tie1_GntA", {7'd0, GntA1}, 8'h00);
        step();
        chk("tie0_F", F0, 8'h3C);
        chk("tie0_FValid", {7'd0, FValid0}, 8'h01);
        chk("tie1_F", F1, 8'hC3);

        // Single requester B
        ReqA = 1'b0; ReqB = 1'b1; B = 8'h5A;
        #1;
        chk("singleB_GntB", {7'd0, GntB0}, 8'h01);
        chk("singleB_Sel", {7'd0, Sel0}, 8'h01);
        step();
        chk("singleB_F", F0, 8'h5A);
        chk("singleB_FValid", {7'd0, FValid0}, 8'h01);
        ReqB = 1'b0;
        #1;
        chk("idle_GntB", {7'd0, GntB0}, 8'h00);
        step();
        chk("drain_FValid", {7'd0, FValid0}, 8'h00);
        chk("drain_F_hold", F0, 8'h5A);

        // Continuous alternation, Last = B so A goes first
        ReqA = 1'b1; ReqB = 1'b1; A = 8'h11; B = 8'h22;
        #1;
        chk("alt_first_GntA", {7'd0, GntA0}, 8'h01);
        step();
        chk("alt_F1", F0, 8'h11);
        chk("alt_GntB", {7'd0, GntB0}, 8'h01);
        step();
        chk("alt_F2", F0, 8'h22);
        step();
        chk("alt_F3", F0, 8'h11);
        step();
        chk("alt_F4", F0, 8'h22);
        chk("alt_FValid", {7'd0, FValid0}, 8'h01);
        step();
        chk("alt_F5", F0, 8'h11);

        // Backpressure: F=11 held, B waiting
        ReqA = 1'b0; ReqB = 1'b1; FReady = 1'b0;
        #1;
        chk("bp_GntB", {7'd0, GntB0}, 8'h00);
        chk("bp_GntA", {7'd0, GntA0}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_F", F0, 8'h11);
            chk("bp_FValid", {7'd0, FValid0}, 8'h01);
            chk("bp_GntB_hold", {7'd0, GntB0}, 8'h00);
        end
        FReady = 1'b1;
        #1;
        chk("bp_release_GntB", {7'd0, GntB0}, 8'h01);
        step();
        chk("bp_release_F", F0, 8'h22);
        chk("bp_release_FValid", {7'd0, FValid0}, 8'h01);

        // Reset mid-operation with a buffered 7E and ReqA high
        ReqB = 1'b0; ReqA = 1'b1; A = 8'h7E;
        #1;
        chk("pre_rst_GntA", {7'd0, GntA0}, 8'h01);
        step();
        chk("pre_rst_F", F0, 8'h7E);
        rst = 1'b1;
        #1;
        chk("rst_GntA_void", {7'd0, GntA0}, 8'h00);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_F", F0, 8'h00);
        chk("midrst_FValid", {7'd0, FValid0}, 8'h00);

        // Next tie goes to FIRST_PRI on each build
        ReqA = 1'b1; ReqB = 1'b1; A = 8'h3C; B = 8'hC3;
        #1;
        chk("rtie0_GntA", {7'd0, GntA0}, 8'h01);
        chk("rtie1_GntB", {7'd0, GntB1}, 8'h01);
        step();
        chk("rtie0_F", F0, 8'h3C);
        chk("rtie1_F", F1, 8'hC3);

        // Idle: Sel points away from last winner (A), buffer drains
        ReqA = 1'b0; ReqB = 1'b0;
        #1;
        chk("idle_Sel", {7'd0, Sel0}, 8'h01);
        step();
        chk("idle_FValid", {7'd0, FValid0}, 8'h00);
        chk("idle_F_hold", F0, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
